// File: rtl/inst_fifo.sv
// inst_fifo: packet queue between fetch and decode. Each entry holds a
// whole 4-slot fetch packet; entries leave strictly in arrival order.
module inst_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_back,
  input  logic              hint,
  input  logic [3:0]        find_inst,
  input  logic [3:0][31:0]  pc,
  input  logic [3:0][31:0]  inst,
  input  logic [3:0][31:0]  target_predict,
  input  logic [3:0]        Predict,
  input  logic [3:0]        has_excp,
  input  logic [3:0][4:0]   excp_code,
  input  logic              stall_dec,
  output logic              full_ififo,
  output logic              valid_out,
  output logic [3:0]        slot_valid_out,
  output logic [3:0][31:0]  pc_out,
  output logic [3:0][31:0]  inst_out,
  output logic [3:0]        Predict_out,
  output logic [3:0][31:0]  target_predict_out,
  output logic [3:0]        has_excp_out,
  output logic [3:0][4:0]   excp_code_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C   = DEPTH[AW:0];
  localparam logic [AW:0] FULL_TH_C = DEPTH_C - 1'b1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Slot-valid storage is the only entry storage that needs clearing;
  // the payload is never observed without a valid head.
  logic [3:0]        r_sv_mem   [DEPTH];
  logic [3:0][31:0]  r_pc_mem   [DEPTH];
  logic [3:0][31:0]  r_inst_mem [DEPTH];
  logic [3:0][31:0]  r_tgt_mem  [DEPTH];
  logic [3:0]        r_pred_mem [DEPTH];
  logic [3:0]        r_excp_mem [DEPTH];
  logic [3:0][4:0]   r_code_mem [DEPTH];

  logic w_valid;
  logic w_wr_en;
  logic w_rd_en;

  assign w_valid = (r_count != '0);
  // A full queue refuses writes even when a pop happens the same cycle.
  assign w_wr_en = hint && (find_inst != 4'b0000) && (r_count < DEPTH_C) && !flush_back;
  assign w_rd_en = w_valid && !stall_dec && !flush_back;

  assign valid_out  = w_valid;
  // One entry of slack covers the packet already held in the fetch register.
  assign full_ififo = (r_count >= FULL_TH_C);

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_back) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot-valid store, cleared by reset; a slot is valid only with hint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sv_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_sv_mem[r_wr_ptr] <= find_inst & {4{hint}};
    end
  end

  // Payload store, written with the packet fields untouched.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_pc_mem[r_wr_ptr]   <= pc;
      r_inst_mem[r_wr_ptr] <= inst;
      r_tgt_mem[r_wr_ptr]  <= target_predict;
      r_pred_mem[r_wr_ptr] <= Predict;
      r_excp_mem[r_wr_ptr] <= has_excp;
      r_code_mem[r_wr_ptr] <= excp_code;
    end
  end

  // Head packet presented combinationally, forced to zero when empty.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_valid_out[gi]     = w_valid & r_sv_mem[r_rd_ptr][gi];
      assign Predict_out[gi]        = w_valid & r_pred_mem[r_rd_ptr][gi];
      assign has_excp_out[gi]       = w_valid & r_excp_mem[r_rd_ptr][gi];
      assign pc_out[gi]             = w_valid ? r_pc_mem[r_rd_ptr][gi]   : 32'h0;
      assign inst_out[gi]           = w_valid ? r_inst_mem[r_rd_ptr][gi] : 32'h0;
      assign target_predict_out[gi] = w_valid ? r_tgt_mem[r_rd_ptr][gi]  : 32'h0;
      assign excp_code_out[gi]      = w_valid ? r_code_mem[r_rd_ptr][gi] : 5'h0;
    end
  endgenerate

endmodule

// File: tb/tb_inst_fifo.sv
// Bench for inst_fifo: directed scenarios plus random traffic, checked
// against a queue-of-packets reference model.
module tb_inst_fifo;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]       sv;
    logic [3:0][31:0] pc;
    logic [3:0][31:0] inst;
    logic [3:0][31:0] tgt;
    logic [3:0]       pred;
    logic [3:0]       excp;
    logic [3:0][4:0]  code;
  } pkt_t;

  logic             clk = 0;
  logic             rst;
  logic             flush_back;
  logic             hint;
  logic [3:0]       find_inst;
  logic [3:0][31:0] pc;
  logic [3:0][31:0] inst;
  logic [3:0][31:0] target_predict;
  logic [3:0]       Predict;
  logic [3:0]       has_excp;
  logic [3:0][4:0]  excp_code;
  logic             stall_dec;
  logic             full_ififo;
  logic             valid_out;
  logic [3:0]       slot_valid_out;
  logic [3:0][31:0] pc_out;
  logic [3:0][31:0] inst_out;
  logic [3:0]       Predict_out;
  logic [3:0][31:0] target_predict_out;
  logic [3:0]       has_excp_out;
  logic [3:0][4:0]  excp_code_out;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  pkt_t q[$];

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_back(flush_back), .hint,
    .find_inst(find_inst), .pc(pc), .inst(inst), .target_predict(target_predict),
    .Predict(Predict), .has_excp(has_excp), .excp_code(excp_code),
    .stall_dec(stall_dec), .full_ififo(full_ififo), .valid_out(valid_out),
    .slot_valid_out(slot_valid_out), .pc_out(pc_out), .inst_out(inst_out),
    .Predict_out(Predict_out), .target_predict_out(target_predict_out),
    .has_excp_out(has_excp_out), .excp_code_out(excp_code_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model's view: head of queue or all zero.
  task automatic check_outputs(input string tag);
    pkt_t e;
    e.sv = '0; e.pc = '0; e.inst = '0; e.tgt = '0; e.pred = '0; e.excp = '0; e.code = '0;
    if (q.size() != 0) e = q[0];
    chk({tag, ".valid"}, 128'(valid_out), 128'(q.size() != 0));
    chk({tag, ".full"},  128'(full_ififo), 128'(q.size() >= DEPTH - 1));
    chk({tag, ".sv"},    128'(slot_valid_out), 128'(e.sv));
    chk({tag, ".pc"},    pc_out, e.pc);
    chk({tag, ".inst"},  inst_out, e.inst);
    chk({tag, ".tgt"},   target_predict_out, e.tgt);
    chk({tag, ".pred"},  128'(Predict_out), 128'(e.pred));
    chk({tag, ".excp"},  128'(has_excp_out), 128'(e.excp));
    chk({tag, ".code"},  128'(excp_code_out), 128'(e.code));
    $display("%0t %s hint=%b find=%b stall=%b flush=%b model_count=%0d valid=%b full=%b",
             $time, tag, hint, find_inst, stall_dec, flush_back, q.size(), valid_out, full_ififo);
  endtask

  task automatic rand_payload();
    for (int s = 0; s < 4; s++) begin
      pc[s]             = $urandom;
      inst[s]           = $urandom;
      target_predict[s] = $urandom;
      excp_code[s]      = 5'($urandom);
    end
    Predict  = 4'($urandom);
    has_excp = 4'($urandom);
  endtask

  // One clock of traffic: model decides accept/pop from its own occupancy.
  task automatic step(input string tag);
    bit   acc, pop;
    pkt_t p, tmp;
    acc = hint && (find_inst != 4'b0) && (q.size() < DEPTH) && !flush_back;
    pop = (q.size() != 0) && !stall_dec && !flush_back;
    p.sv = find_inst & {4{hint}}; p.pc = pc; p.inst = inst; p.tgt = target_predict;
    p.pred = Predict; p.excp = has_excp; p.code = excp_code;
    @(posedge clk);
    if (flush_back) q.delete();
    else begin
      if (pop) tmp = q.pop_front();
      if (acc) q.push_back(p);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic write_pkts(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      hint = 1; find_inst = 4'hf; stall_dec = 1; rand_payload();
      step(tag);
    end
    hint = 0;
  endtask

  task automatic drain(input string tag);
    hint = 0; stall_dec = 0;
    for (int i = 0; i < DEPTH + 1; i++) step(tag);
  endtask

  initial begin
    rst = 1; flush_back = 0; hint = 0; find_inst = 0; stall_dec = 0;
    pc = '0; inst = '0; target_predict = '0; Predict = 0; has_excp = 0; excp_code = '0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 0;

    // Single packet with known PCs, visible one cycle later.
    hint = 1; find_inst = 4'hf; stall_dec = 1; rand_payload();
    for (int s = 0; s < 4; s++) pc[s] = 32'h1c000000 + 32'(4 * s);
    step("first");
    chk("first.pc0", 128'(pc_out[0]), 128'(32'h1c000000));
    chk("first.sv_all", 128'(slot_valid_out), 128'(4'b1111));

    // Fill under stall, overflow packet dropped, then in-order drain.
    write_pkts(3, "fill");
    write_pkts(1, "overflow");
    chk("overflow.full", 128'(full_ififo), 128'(1'b1));
    drain("drain");
    chk("drain.empty", 128'(valid_out), 128'(1'b0));

    // Steady simultaneous write/read at occupancy 2 across pointer wrap.
    write_pkts(2, "pre2");
    stall_dec = 0; hint = 1; find_inst = 4'hf;
    for (int i = 0; i < 10; i++) begin
      rand_payload();
      step("wr_rd");
    end
    drain("drain2");

    // Write qualification by hint and find_inst.
    hint = 1; find_inst = 4'b0000; stall_dec = 1; rand_payload(); step("nofind");
    hint = 0; find_inst = 4'b1111; rand_payload(); step("nohint");
    hint = 1; find_inst = 4'b0011; rand_payload(); step("partial");
    chk("partial.sv", 128'(slot_valid_out), 128'(4'b0011));
    drain("drain3");

    // Flush with a concurrent incoming packet.
    write_pkts(3, "pre_flush");
    flush_back = 1; hint = 1; find_inst = 4'hf; rand_payload();
    step("flush");
    chk("flush.valid", 128'(valid_out), 128'(1'b0));
    flush_back = 0; hint = 0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      hint       = ($urandom_range(0, 3) != 0);
      find_inst  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      stall_dec  = ($urandom_range(0, 2) == 0);
      flush_back = ($urandom_range(0, 31) == 0);
      rand_payload();
      step("rand");
    end
    flush_back = 0;
    drain("drain4");

    // Asynchronous reset between clock edges at occupancy 3.
    write_pkts(3, "pre_rst");
    #2 rst = 1;
    #1;
    q.delete();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 0;
    hint = 0; stall_dec = 0;
    step("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
